sram_axi_bridge_ot: RTL and testbench

Parametrised successor of the CPU's SRAM-like-to-AXI bridge. It supports multiple outstanding reads per port, up to WR_OT outstanding writes, and independent AW/W handshakes. Request size is forwarded to AXI. It sits between the IF/EX/MEM SRAM-like ports and the single AXI master interface. In-order data_ok per port is guaranteed by per-ID ordering and a data-port read/write type-switch interlock.

---
 rtl/sram_axi_bridge_ot_pkg.sv | 23 ++
 rtl/sram_axi_bridge_ot_if.sv | 80 ++++++++
 rtl/sram_axi_bridge_ot_counter.sv | 32 +++
 rtl/sram_axi_bridge_ot.sv | 153 +++++++++++++++
 tb/tb_sram_axi_bridge_ot.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/sram_axi_bridge_ot_pkg.sv
// Shared constants for the SRAM-like to AXI bridge: AXI IDs, fixed AXI attribute fields
// and the size-to-axsize mapping.
package sram_axi_bridge_ot_pkg;

    localparam logic [3:0] ID_INST    = 4'd0;
    localparam logic [3:0] ID_DATA    = 4'd1;
    localparam logic [3:0] ID_WR      = 4'd1;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [7:0] AXI_LEN    = 8'd0;
    localparam logic [1:0] AXI_LOCK   = 2'b00;
    localparam logic [3:0] AXI_CACHE  = 4'b0000;
    localparam logic [2:0] AXI_PROT   = 3'b000;

    typedef struct packed {
        logic [3:0] id;
        logic [2:0] size;
    } ax_attr_t;

    function automatic logic [2:0] size_to_axsize(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/sram_axi_bridge_ot_if.sv
// Bundles for the SRAM-like request ports and the single-beat AXI master port.
// master = the side that issues requests, slave = the side that answers them.
interface sram_axi_bridge_ot_sram_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
    logic                  req;
    logic                  wr;
    logic [1:0]            size;
    logic [DATA_W/8-1:0]   wstrb;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic                  addr_ok;
    logic                  data_ok;
    logic [DATA_W-1:0]     rdata;

    modport master (output req, wr, size, wstrb, addr, wdata, input addr_ok, data_ok, rdata);
    modport slave  (input req, wr, size, wstrb, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

interface sram_axi_bridge_ot_axi_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
    logic [3:0]          arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic [1:0]          arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [3:0]          rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;
    logic [3:0]          awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [1:0]          awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [3:0]          wid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [3:0]          bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );
    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/sram_axi_bridge_ot_counter.sv
// Outstanding-transaction counter, 0..MAX: +1 on i_inc, -1 on i_dec, unchanged when both.
// A decrement at zero is dropped so a stray response cannot wrap the count.
module ot_counter #(
    parameter int MAX = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_full,
    output logic o_zero
);
    localparam int CNT_W = $clog2(MAX + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_dec;

    assign w_dec  = i_dec & ~o_zero;
    assign o_full = (r_cnt == CNT_W'(MAX));
    assign o_zero = (r_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_inc && !w_dec) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (!i_inc && w_dec) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/sram_axi_bridge_ot.sv
// Bridges the IF and EX/MEM SRAM-like ports onto one AXI master with per-port outstanding reads.
// addr_ok is combinational from state; data_ok arrives one cycle after the R/B beat; rready/bready are always high.
module sram_axi_bridge_ot
    import sram_axi_bridge_ot_pkg::*;
#(
    parameter int RD_OT  = 2,
    parameter int WR_OT  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    sram_axi_bridge_ot_sram_if.slave  inst_sram,
    sram_axi_bridge_ot_sram_if.slave  data_sram,
    sram_axi_bridge_ot_axi_if.master  axi
);

    logic                r_ar_vld;
    ax_attr_t            r_ar_attr;
    logic [ADDR_W-1:0]   r_ar_addr;
    logic                r_aw_pend;
    logic                r_w_pend;
    logic [ADDR_W-1:0]   r_aw_addr;
    logic [2:0]          r_aw_size;
    logic [DATA_W/8-1:0] r_wstrb;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_i_data_ok;
    logic                r_d_data_ok;
    logic [DATA_W-1:0]   r_rdata;

    logic w_ar_free;
    logic w_rd_i_full, w_rd_i_zero, w_rd_d_full, w_rd_d_zero, w_wr_full, w_wr_zero;
    logic w_d_rd_ok, w_d_wr_ok, w_i_rd_ok;
    logic w_d_rd_acc, w_d_wr_acc, w_i_rd_acc;
    logic w_r_inst, w_r_data;

    // The slot may be reloaded in the same cycle its previous request is taken by the slave.
    assign w_ar_free  = ~r_ar_vld | axi.arready;

    // Data reads and writes never overlap, which keeps data_ok in request order on the data port.
    assign w_d_rd_ok  = w_ar_free & ~w_rd_d_full & w_wr_zero;
    assign w_d_wr_ok  = ~r_aw_pend & ~r_w_pend & ~w_wr_full & w_rd_d_zero;
    assign w_d_rd_acc = data_sram.req & ~data_sram.wr & w_d_rd_ok;
    assign w_d_wr_acc = data_sram.req &  data_sram.wr & w_d_wr_ok;
    assign w_i_rd_ok  = w_ar_free & ~w_rd_i_full & ~w_d_rd_acc;
    assign w_i_rd_acc = inst_sram.req & w_i_rd_ok;

    assign w_r_inst   = axi.rvalid & (axi.rid == ID_INST);
    assign w_r_data   = axi.rvalid & (axi.rid == ID_DATA);

    assign inst_sram.addr_ok = w_i_rd_ok;
    assign data_sram.addr_ok = data_sram.wr ? w_d_wr_ok : w_d_rd_ok;
    assign inst_sram.data_ok = r_i_data_ok;
    assign data_sram.data_ok = r_d_data_ok;
    assign inst_sram.rdata   = r_rdata;
    assign data_sram.rdata   = r_rdata;

    ot_counter #(.MAX(RD_OT)) u_rd_i_cnt (
        .clk(clk), .reset(reset), .i_inc(w_i_rd_acc), .i_dec(w_r_inst),
        .o_full(w_rd_i_full), .o_zero(w_rd_i_zero)
    );
    ot_counter #(.MAX(RD_OT)) u_rd_d_cnt (
        .clk(clk), .reset(reset), .i_inc(w_d_rd_acc), .i_dec(w_r_data),
        .o_full(w_rd_d_full), .o_zero(w_rd_d_zero)
    );
    ot_counter #(.MAX(WR_OT)) u_wr_cnt (
        .clk(clk), .reset(reset), .i_inc(w_d_wr_acc), .i_dec(axi.bvalid),
        .o_full(w_wr_full), .o_zero(w_wr_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ar_vld  <= 1'b0;
            r_ar_attr <= '0;
            r_ar_addr <= '0;
        end else if (w_d_rd_acc) begin
            r_ar_vld  <= 1'b1;
            r_ar_attr <= '{id: ID_DATA, size: size_to_axsize(data_sram.size)};
            r_ar_addr <= data_sram.addr;
        end else if (w_i_rd_acc) begin
            r_ar_vld  <= 1'b1;
            r_ar_attr <= '{id: ID_INST, size: size_to_axsize(inst_sram.size)};
            r_ar_addr <= inst_sram.addr;
        end else if (axi.arready) begin
            r_ar_vld  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_aw_pend <= 1'b0;
            r_w_pend  <= 1'b0;
            r_aw_addr <= '0;
            r_aw_size <= '0;
            r_wstrb   <= '0;
            r_wdata   <= '0;
        end else if (w_d_wr_acc) begin
            r_aw_pend <= 1'b1;
            r_w_pend  <= 1'b1;
            r_aw_addr <= data_sram.addr;
            r_aw_size <= size_to_axsize(data_sram.size);
            r_wstrb   <= data_sram.wstrb;
            r_wdata   <= data_sram.wdata;
        end else begin
            if (axi.awready) r_aw_pend <= 1'b0;
            if (axi.wready)  r_w_pend  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_i_data_ok <= 1'b0;
            r_d_data_ok <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_i_data_ok <= w_r_inst;
            r_d_data_ok <= w_r_data | axi.bvalid;
            if (axi.rvalid) r_rdata <= axi.rdata;
        end
    end

    assign axi.arid    = r_ar_attr.id;
    assign axi.araddr  = r_ar_addr;
    assign axi.arlen   = AXI_LEN;
    assign axi.arsize  = r_ar_attr.size;
    assign axi.arburst = BURST_INCR;
    assign axi.arlock  = AXI_LOCK;
    assign axi.arcache = AXI_CACHE;
    assign axi.arprot  = AXI_PROT;
    assign axi.arvalid = r_ar_vld;
    assign axi.rready  = ~reset;

    assign axi.awid    = ID_WR;
    assign axi.awaddr  = r_aw_addr;
    assign axi.awlen   = AXI_LEN;
    assign axi.awsize  = r_aw_size;
    assign axi.awburst = BURST_INCR;
    assign axi.awlock  = AXI_LOCK;
    assign axi.awcache = AXI_CACHE;
    assign axi.awprot  = AXI_PROT;
    assign axi.awvalid = r_aw_pend;
    assign axi.wid     = ID_WR;
    assign axi.wdata   = r_wdata;
    assign axi.wstrb   = r_wstrb;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = r_w_pend;
    assign axi.bready  = ~reset;

    logic w_unused_ok;
    assign w_unused_ok = ^{inst_sram.wr, inst_sram.wstrb, inst_sram.wdata, axi.rresp, axi.rlast,
                           axi.bid, axi.bresp, w_rd_i_zero};

endmodule

// File: tb/tb_sram_axi_bridge_ot.sv
// Randomised traffic against a queue-based reference of the bridge; a separate monitor
// scores AXI request channels and SRAM-like responses.
module tb_sram_axi_bridge_ot;

    localparam int RD_OT = 2;
    localparam int WR_OT = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sram_axi_bridge_ot_sram_if inst_if ();
    sram_axi_bridge_ot_sram_if data_if ();
    sram_axi_bridge_ot_axi_if  axi_if ();

    sram_axi_bridge_ot #(.RD_OT(RD_OT), .WR_OT(WR_OT), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .inst_sram(inst_if), .data_sram(data_if), .axi(axi_if)
    );

    typedef struct { logic [3:0] id; logic [31:0] addr; logic [2:0] size; } ax_t;
    typedef struct { logic [31:0] data; logic [3:0] strb; } w_t;
    typedef struct { bit is_wr; logic [31:0] data; } rsp_t;
    typedef struct { logic [3:0] id; logic [31:0] addr; int due; } rd_t;

    ax_t         exp_ar[$];
    ax_t         exp_aw[$];
    w_t          exp_w[$];
    logic [31:0] exp_i[$];
    rsp_t        exp_d[$];
    rd_t         rd_q[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // Reference state: outstanding counts and the single AR / AW / W request slots.
    int i_out, d_out, wr_out, aw_cnt, w_cnt, b_sent;
    bit ar_pend, awp, wp;
    logic [3:0]  pend_id;
    logic [31:0] pend_addr;
    bit cur_ri, cur_rd, cur_b, prev_ri, prev_rd, prev_b;
    bit hold_rsp, ar_block;

    function automatic logic [31:0] rmem(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h3c5a_96e1;
    endfunction

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_model();
        i_out = 0; d_out = 0; wr_out = 0; aw_cnt = 0; w_cnt = 0; b_sent = 0;
        ar_pend = 0; awp = 0; wp = 0; pend_id = '0; pend_addr = '0;
        cur_ri = 0; cur_rd = 0; cur_b = 0; prev_ri = 0; prev_rd = 0; prev_b = 0;
        exp_ar.delete(); exp_aw.delete(); exp_w.delete(); exp_i.delete(); exp_d.delete(); rd_q.delete();
        inst_if.req = 0; data_if.req = 0; axi_if.rvalid = 0; axi_if.bvalid = 0;
    endtask

    task automatic cycle(input bit gen);
        bit ar_free, d_rd_ok, d_wr_ok, d_rd_acc, d_wr_acc, i_ok, i_acc;
        @(posedge clk);
        #1;
        prev_ri = cur_ri; prev_rd = cur_rd; prev_b = cur_b;
        inst_if.req   = gen && ($urandom_range(0, 9) < 6);
        inst_if.wr    = ($urandom_range(0, 1) == 1);
        inst_if.size  = 2'd2;
        inst_if.wstrb = 4'($urandom);
        inst_if.wdata = $urandom;
        inst_if.addr  = 32'h1c00_0000 + 32'($urandom_range(0, 63)) * 4;
        data_if.req   = gen && ($urandom_range(0, 9) < 5);
        data_if.wr    = ($urandom_range(0, 9) < 4);
        data_if.size  = 2'($urandom_range(0, 2));
        data_if.wstrb = 4'($urandom);
        data_if.wdata = $urandom;
        data_if.addr  = 32'($urandom_range(0, 255)) * 4;
        axi_if.arready = !ar_block && ($urandom_range(0, 3) != 0);
        axi_if.awready = ($urandom_range(0, 2) != 0);
        axi_if.wready  = ($urandom_range(0, 2) != 0);
        cur_ri = 0; cur_rd = 0; cur_b = 0;
        axi_if.rvalid = 0; axi_if.rid = '0; axi_if.rdata = '0;
        if (!hold_rsp && rd_q.size() != 0 && rd_q[0].due <= cyc && $urandom_range(0, 3) != 0) begin
            axi_if.rvalid = 1; axi_if.rid = rd_q[0].id; axi_if.rdata = rmem(rd_q[0].addr);
            cur_ri = (rd_q[0].id == 4'd0); cur_rd = (rd_q[0].id == 4'd1);
            void'(rd_q.pop_front());
        end else if (!hold_rsp && $urandom_range(0, 19) == 0) begin
            axi_if.rvalid = 1; axi_if.rid = 4'($urandom_range(2, 15)); axi_if.rdata = $urandom;
        end
        axi_if.bvalid = 0;
        if (!hold_rsp && b_sent < aw_cnt && b_sent < w_cnt && $urandom_range(0, 1) == 1) begin
            axi_if.bvalid = 1; b_sent++; cur_b = 1;
        end
        @(negedge clk);
        ar_free  = !ar_pend || axi_if.arready;
        d_rd_ok  = ar_free && d_out < RD_OT && wr_out == 0;
        d_wr_ok  = !awp && !wp && wr_out < WR_OT && d_out == 0;
        d_rd_acc = data_if.req && !data_if.wr && d_rd_ok;
        d_wr_acc = data_if.req && data_if.wr && d_wr_ok;
        i_ok     = ar_free && i_out < RD_OT && !d_rd_acc;
        i_acc    = inst_if.req && i_ok;
        chk_eq("inst_addr_ok", 64'(inst_if.addr_ok), 64'(i_ok));
        chk_eq("data_addr_ok", 64'(data_if.addr_ok), 64'(data_if.wr ? d_wr_ok : d_rd_ok));
        chk_eq("valid_ready", 64'({axi_if.arvalid, axi_if.awvalid, axi_if.wvalid, axi_if.rready, axi_if.bready}),
               64'({ar_pend, awp, wp, 2'b11}));
        if (ar_pend && axi_if.arready) begin
            rd_q.push_back('{pend_id, pend_addr, cyc + 1 + int'($urandom_range(0, 3))});
            ar_pend = 0;
        end
        if (awp && axi_if.awready) begin awp = 0; aw_cnt++; end
        if (wp && axi_if.wready) begin wp = 0; w_cnt++; end
        if (d_rd_acc) begin
            ar_pend = 1; pend_id = 4'd1; pend_addr = data_if.addr;
            exp_ar.push_back('{4'd1, data_if.addr, {1'b0, data_if.size}});
            exp_d.push_back('{1'b0, rmem(data_if.addr)});
            d_out++;
        end else if (i_acc) begin
            ar_pend = 1; pend_id = 4'd0; pend_addr = inst_if.addr;
            exp_ar.push_back('{4'd0, inst_if.addr, {1'b0, inst_if.size}});
            exp_i.push_back(rmem(inst_if.addr));
            i_out++;
        end
        if (d_wr_acc) begin
            awp = 1; wp = 1;
            exp_aw.push_back('{4'd1, data_if.addr, {1'b0, data_if.size}});
            exp_w.push_back('{data_if.wdata, data_if.wstrb});
            exp_d.push_back('{1'b1, 32'h0});
            wr_out++;
        end
        if (cur_ri) i_out--;
        if (cur_rd) d_out--;
        if (cur_b)  wr_out--;
        cyc++;
    endtask

    // Monitor: checks every AXI request handshake and every SRAM-like response.
    initial begin
        ax_t ea;
        w_t ew;
        rsp_t er;
        logic [31:0] ei;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (axi_if.arvalid && axi_if.arready) begin
                    chk_eq("ar_expected", 64'(exp_ar.size() != 0), 64'(1));
                    if (exp_ar.size() != 0) begin
                        ea = exp_ar.pop_front();
                        chk_eq("ar_fields", 64'({axi_if.arid, axi_if.araddr, axi_if.arsize, axi_if.arlen, axi_if.arburst,
                                                 axi_if.arlock, axi_if.arcache, axi_if.arprot}),
                               64'({ea.id, ea.addr, ea.size, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0}));
                    end
                end
                if (axi_if.awvalid && axi_if.awready) begin
                    chk_eq("aw_expected", 64'(exp_aw.size() != 0), 64'(1));
                    if (exp_aw.size() != 0) begin
                        ea = exp_aw.pop_front();
                        chk_eq("aw_fields", 64'({axi_if.awid, axi_if.awaddr, axi_if.awsize, axi_if.awlen, axi_if.awburst,
                                                 axi_if.awlock, axi_if.awcache, axi_if.awprot}),
                               64'({ea.id, ea.addr, ea.size, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0}));
                    end
                end
                if (axi_if.wvalid && axi_if.wready) begin
                    chk_eq("w_expected", 64'(exp_w.size() != 0), 64'(1));
                    if (exp_w.size() != 0) begin
                        ew = exp_w.pop_front();
                        chk_eq("w_fields", 64'({axi_if.wid, axi_if.wdata, axi_if.wstrb, axi_if.wlast}),
                               64'({4'd1, ew.data, ew.strb, 1'b1}));
                    end
                end
                chk_eq("inst_data_ok", 64'(inst_if.data_ok), 64'(prev_ri));
                if (inst_if.data_ok && exp_i.size() != 0) begin
                    ei = exp_i.pop_front();
                    chk_eq("inst_rdata", 64'(inst_if.rdata), 64'(ei));
                end
                chk_eq("data_data_ok", 64'(data_if.data_ok), 64'(prev_rd || prev_b));
                if (data_if.data_ok && exp_d.size() != 0) begin
                    er = exp_d.pop_front();
                    if (!er.is_wr) chk_eq("data_rdata", 64'(data_if.rdata), 64'(er.data));
                end
            end
        end
    end

    initial begin
        int k;
        inst_if.wr = 0; inst_if.size = 0; inst_if.wstrb = 0; inst_if.addr = 0; inst_if.wdata = 0;
        data_if.wr = 0; data_if.size = 0; data_if.wstrb = 0; data_if.addr = 0; data_if.wdata = 0;
        axi_if.arready = 0; axi_if.awready = 0; axi_if.wready = 0;
        axi_if.rid = 0; axi_if.rdata = 0; axi_if.rresp = 0; axi_if.rlast = 1;
        axi_if.bid = 4'd1; axi_if.bresp = 0;
        hold_rsp = 0; ar_block = 0;
        clear_model();
        repeat (3) @(posedge clk);
        #3 reset = 0;
        #1;
        chk_eq("reset_state", 64'({axi_if.arvalid, axi_if.awvalid, axi_if.wvalid, inst_if.data_ok, data_if.data_ok,
                                   axi_if.rready, axi_if.bready}), 64'(7'b0000011));
        chk_eq("reset_rdata", 64'({inst_if.rdata, data_if.rdata}), 64'h0);

        repeat (800) cycle(1);

        // Park reads in flight and an AR request in the slot, then reset mid-cycle.
        hold_rsp = 1;
        repeat (6) cycle(1);
        ar_block = 1;
        repeat (3) cycle(1);
        @(posedge clk);
        #3 reset = 1;
        #1;
        chk_eq("async_reset_valids", 64'({axi_if.arvalid, axi_if.awvalid, axi_if.wvalid, inst_if.data_ok, data_if.data_ok}),
               64'h0);
        chk_eq("async_reset_rdata", 64'({inst_if.rdata, data_if.rdata}), 64'h0);
        clear_model();
        hold_rsp = 0; ar_block = 0;
        repeat (2) @(posedge clk);
        #3 reset = 0;

        repeat (800) cycle(1);

        k = 0;
        while ((exp_ar.size() + exp_aw.size() + exp_w.size() + exp_i.size() + exp_d.size() + rd_q.size()) != 0 && k < 400) begin
            cycle(0);
            k++;
        end
        repeat (4) cycle(0);
        chk_eq("drain_inst_rsp", 64'(exp_i.size()), 64'(0));
        chk_eq("drain_data_rsp", 64'(exp_d.size()), 64'(0));
        chk_eq("drain_axi_req", 64'(exp_ar.size() + exp_aw.size() + exp_w.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
